// File: rtl/xcore_uart_tx_pkg.sv
// Shared definitions for the xcore transmit UART: register map, bit layout, FSM encoding.
package xcore_uart_tx_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned BAUD_W = 16;

   localparam logic [ADDR_W-1:0] UART_TXDATA = 4'h0;
   localparam logic [ADDR_W-1:0] UART_STATUS = 4'h4;
   localparam logic [ADDR_W-1:0] UART_CTRL   = 4'h8;

   localparam int unsigned ST_FULL    = 0;
   localparam int unsigned ST_EMPTY   = 1;
   localparam int unsigned ST_BUSY    = 2;
   localparam int unsigned ST_OVF     = 3;
   localparam int unsigned ST_CNT_LSB = 8;
   localparam int unsigned CTRL_EN    = 0;
   localparam int unsigned CTRL_IE    = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

   // STATUS read image, LSB = full
   typedef struct packed {
      logic [7:0] count;
      logic [3:0] rsvd;
      logic       ovf;
      logic       busy;
      logic       empty;
      logic       full;
   } status_t;

   typedef struct packed {
      logic ie;
      logic en;
   } ctrl_t;

endpackage

// File: rtl/xcore_uart_tx_if.sv
// Register-bus port of the transmit UART.
interface xcore_uart_tx_if;
   import xcore_uart_tx_pkg::*;

   logic              we_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i;
   logic [DATA_W-1:0] rdata_o;

   modport master (output we_i, output addr_i, output wdata_i, input rdata_o);
   modport slave  (input we_i, input addr_i, input wdata_i, output rdata_o);

endinterface

// File: rtl/xcore_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; head word visible combinationally.
module xcore_sync_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata_c,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_full;
   logic             r_empty;
   logic             w_do_push;
   logic             w_do_pop;
   logic [CW-1:0]    w_count_nxt;

   // A push on a full FIFO is dropped even if a pop happens on the same edge
   assign w_do_push   = i_push && !r_full;
   assign w_do_pop    = i_pop && !r_empty;
   assign w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata_c = r_mem[r_rd_ptr];
   assign o_full    = r_full;
   assign o_empty   = r_empty;
   assign o_count   = r_count;

endmodule

// File: rtl/xcore_uart_tx.sv
// Memory-mapped transmit-only UART: bus decode, TX FIFO and 8N1 serializer.
module xcore_uart_tx
   import xcore_uart_tx_pkg::*;
#(
   parameter int unsigned BAUD_DIV   = 434,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   xcore_uart_tx_if.slave  bus,
   output logic            tx_o,
   output logic            irq_o
);

   localparam int unsigned       FCNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

   logic              w_push_req;
   logic              w_stat_wr;
   logic              w_ctrl_wr;
   logic              w_pop;
   logic [BYTE_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic [FCNT_W-1:0] w_count;
   logic              w_unused_wdata;

   logic              r_en;
   logic              r_ie;
   logic              r_ovf;

   tx_state_e         r_state;
   tx_state_e         w_state_nxt;
   logic [BAUD_W-1:0] r_baud;
   logic [BAUD_W-1:0] w_baud_nxt;
   logic [2:0]        r_bit;
   logic [2:0]        w_bit_nxt;
   logic [BYTE_W-1:0] r_shift;
   logic [BYTE_W-1:0] w_shift_nxt;
   logic              r_tx;
   logic              w_tx_nxt;
   logic              w_can_start;

   status_t           w_status;
   ctrl_t             w_ctrl;
   logic [DATA_W-1:0] w_rdata;

   assign w_push_req     = bus.we_i && (bus.addr_i == UART_TXDATA);
   assign w_stat_wr      = bus.we_i && (bus.addr_i == UART_STATUS);
   assign w_ctrl_wr      = bus.we_i && (bus.addr_i == UART_CTRL);
   assign w_unused_wdata = ^bus.wdata_i[DATA_W-1:BYTE_W];

   xcore_sync_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push_req),
      .i_wdata   (bus.wdata_i[BYTE_W-1:0]),
      .i_pop     (w_pop),
      .o_rdata_c (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   // Control and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_en  <= 1'b1;
         r_ie  <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_en <= bus.wdata_i[CTRL_EN];
            r_ie <= bus.wdata_i[CTRL_IE];
         end
         if (w_stat_wr)                 r_ovf <= 1'b0;
         else if (w_push_req && w_full) r_ovf <= 1'b1;
      end
   end

   assign w_can_start = r_en && !w_empty;

   // Serializer next-state; a new frame may start from IDLE or straight out of STOP
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (w_can_start) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
               w_baud_nxt  = BAUD_LAST;
               w_shift_nxt = w_head;
               w_tx_nxt    = 1'b0;
            end
         end
         S_START: begin
            if (r_baud == '0) begin
               w_state_nxt = S_DATA;
               w_baud_nxt  = BAUD_LAST;
               w_bit_nxt   = 3'd0;
               w_tx_nxt    = r_shift[0];
               w_shift_nxt = r_shift >> 1;
            end else begin
               w_baud_nxt = r_baud - BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (r_baud == '0) begin
               w_baud_nxt = BAUD_LAST;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
                  w_tx_nxt    = r_shift[0];
                  w_shift_nxt = r_shift >> 1;
               end
            end else begin
               w_baud_nxt = r_baud - BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (r_baud == '0) begin
               if (w_can_start) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_START;
                  w_baud_nxt  = BAUD_LAST;
                  w_shift_nxt = w_head;
                  w_tx_nxt    = 1'b0;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_tx_nxt    = 1'b1;
               end
            end else begin
               w_baud_nxt = r_baud - BAUD_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   // Read mux
   always_comb begin
      w_status       = '0;
      w_status.full  = w_full;
      w_status.empty = w_empty;
      w_status.busy  = (r_state != S_IDLE);
      w_status.ovf   = r_ovf;
      w_status.count = 8'(w_count);
      w_ctrl.en      = r_en;
      w_ctrl.ie      = r_ie;
      case (bus.addr_i)
         UART_STATUS: w_rdata = DATA_W'(w_status);
         UART_CTRL:   w_rdata = DATA_W'(w_ctrl);
         default:     w_rdata = '0;
      endcase
   end

   assign bus.rdata_o = w_rdata;
   assign tx_o        = r_tx;
   assign irq_o       = r_ie && w_empty && (r_state == S_IDLE);

endmodule

// File: tb/tb_xcore_uart_tx.sv
// Randomized scoreboard bench for xcore_uart_tx: a line decoder checks every frame against queued bytes.
module tb_xcore_uart_tx;
   import xcore_uart_tx_pkg::*;

   localparam int BAUD  = 4;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst;
   logic tx_o;
   logic irq_o;

   xcore_uart_tx_if bus ();

   xcore_uart_tx #(
      .BAUD_DIV   (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .tx_o  (tx_o),
      .irq_o (irq_o)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // STATUS image built from the register description
   function automatic logic [31:0] st(input int cnt, input bit full, input bit empty,
                                      input bit busy, input bit ovf);
      return (32'(cnt) << 8) | (32'(ovf) << 3) | (32'(busy) << 2) | (32'(empty) << 1) | 32'(full);
   endfunction

   // Ideal 8N1 line level for each of the 10*BAUD cycles of a frame
   function automatic logic [39:0] frame_wave(input logic [7:0] b);
      logic [39:0] w;
      for (int k = 0; k < 10 * BAUD; k++) begin
         int slot = k / BAUD;
         if (slot == 0)      w[k] = 1'b0;
         else if (slot <= 8) w[k] = b[slot-1];
         else                w[k] = 1'b1;
      end
      return w;
   endfunction

   // Line decoder / scoreboard monitor: samples mid-bit, pops expected byte at stop bit
   int         dec_cnt = -1;
   logic [7:0] dec_byte;
   always @(posedge clk) begin
      #1;
      if (rst) begin
         dec_cnt = -1;
      end else begin
         if (dec_cnt < 0) begin
            if (tx_o === 1'b0) dec_cnt = 0;
         end else begin
            dec_cnt++;
         end
         if (dec_cnt >= 0) begin
            for (int i = 0; i < 8; i++)
               if (dec_cnt == BAUD * (i + 1) + BAUD / 2) dec_byte[i] = tx_o;
            if (dec_cnt == 9 * BAUD + BAUD / 2) begin
               check("stop_bit", 64'(tx_o), 64'(1));
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_frame: got 0x%0h, want no frame", dec_byte);
               end else begin
                  check("frame_byte", 64'(dec_byte), 64'(exp_q.pop_front()));
               end
            end
            if (dec_cnt == 10 * BAUD - 1) dec_cnt = -1;
         end
      end
   end

   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.we_i    = 1'b1;
      bus.addr_i  = a;
      bus.wdata_i = d;
      @(negedge clk);
      bus.we_i = 1'b0;
   endtask

   task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
      bus.addr_i = a;
      #1;
      d = bus.rdata_o;
   endtask

   // TXDATA writes on consecutive cycles
   task automatic write_bytes(input logic [7:0] b[$]);
      foreach (b[i]) begin
         @(negedge clk);
         bus.we_i    = 1'b1;
         bus.addr_i  = UART_TXDATA;
         bus.wdata_i = 32'(b[i]);
      end
      @(negedge clk);
      bus.we_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name, output int n);
      logic [31:0] s;
      n = 0;
      bus.addr_i = UART_STATUS;
      forever begin
         @(negedge clk);
         #1;
         s = bus.rdata_o;
         n++;
         if (!s[2] && s[1]) break;
         if (n > budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got still busy after %0d cycles, want idle", name, n);
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic [39:0] wave;
      logic [7:0]  bq[$];
      int          n;
      int          busy_cnt;
      int          model_occ;
      bit          model_ovf;
      bit          all_high;

      rst         = 1'b1;
      bus.we_i    = 1'b0;
      bus.addr_i  = '0;
      bus.wdata_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_tx", 64'(tx_o), 64'(1));
      check("rst_irq", 64'(irq_o), 64'(0));
      bus_rd(UART_STATUS, rd); check("rst_status", 64'(rd), 64'(st(0, 0, 1, 0, 0)));
      bus_rd(UART_CTRL, rd);   check("rst_ctrl", 64'(rd), 64'(1));
      bus_rd(UART_TXDATA, rd); check("rd_txdata", 64'(rd), 64'(0));
      bus_rd(4'hC, rd);        check("rd_undecoded", 64'(rd), 64'(0));

      // Single frame 0x55: waveform and busy window
      bq.delete(); bq.push_back(8'h55); exp_q.push_back(8'h55);
      write_bytes(bq);
      bus_rd(UART_STATUS, rd); check("push_status", 64'(rd), 64'(st(1, 0, 0, 0, 0)));
      check("tx_before_pop", 64'(tx_o), 64'(1));
      busy_cnt = 0;
      for (int k = 0; k < 10 * BAUD; k++) begin
         @(negedge clk);
         #1;
         wave[k] = tx_o;
         busy_cnt += int'(bus.rdata_o[2]);
      end
      check("wave_55", 64'(wave), 64'(frame_wave(8'h55)));
      check("busy_cycles", 64'(busy_cnt), 64'(10 * BAUD));
      @(negedge clk); #1;
      check("busy_after", 64'(bus.rdata_o[2]), 64'(0));

      // "ABC" back to back
      bq.delete(); bq.push_back(8'h41); bq.push_back(8'h42); bq.push_back(8'h43);
      foreach (bq[i]) exp_q.push_back(bq[i]);
      write_bytes(bq);
      bus_rd(UART_STATUS, rd); check("abc_status", 64'(rd), 64'(st(2, 0, 0, 1, 0)));
      wait_idle(300, "abc_idle", n);
      check("abc_length", 64'(n), 64'(30 * BAUD - 1));

      // EN=0, nine pushes: overflow and drop
      bus_wr(UART_CTRL, 32'h0);
      bus_rd(UART_CTRL, rd); check("ctrl_en0", 64'(rd), 64'(0));
      bq.delete(); model_occ = 0; model_ovf = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         bq.push_back(8'($urandom_range(255, 0)));
         if (model_occ < DEPTH) begin
            exp_q.push_back(bq[i]);
            model_occ++;
         end else begin
            model_ovf = 1;
         end
      end
      write_bytes(bq);
      bus_rd(UART_STATUS, rd);
      check("ovf_status", 64'(rd), 64'(st(model_occ, model_occ == DEPTH, 0, 0, model_ovf)));
      bus_wr(UART_STATUS, 32'hFFFF_FFFF);
      bus_rd(UART_STATUS, rd);
      check("ovf_clear", 64'(rd), 64'(st(model_occ, model_occ == DEPTH, 0, 0, 0)));
      bus_wr(UART_CTRL, 32'h1);
      wait_idle(DEPTH * 10 * BAUD + 50, "drain_idle", n);
      bus_rd(UART_STATUS, rd); check("drain_status", 64'(rd), 64'(st(0, 0, 1, 0, 0)));

      // Clear EN mid-DATA with a second byte queued
      bq.delete(); bq.push_back(8'hC3); bq.push_back(8'h3C);
      foreach (bq[i]) exp_q.push_back(bq[i]);
      write_bytes(bq);
      repeat (8) @(negedge clk);
      bus_wr(UART_CTRL, 32'h0);
      bus.addr_i = UART_STATUS;
      n = 0;
      do begin
         @(negedge clk); #1; n++;
      end while (bus.rdata_o[2] && n < 60);
      check("en_off_status", 64'(bus.rdata_o), 64'(st(1, 0, 0, 0, 0)));
      all_high = 1;
      repeat (5 * BAUD) begin
         @(negedge clk); #1;
         if (tx_o !== 1'b1) all_high = 0;
      end
      check("en_off_line_idle", 64'(all_high), 64'(1));
      bus_wr(UART_CTRL, 32'h1);
      wait_idle(100, "en_resume_idle", n);

      // Reset mid-DATA
      bq.delete(); bq.push_back(8'hA5); bq.push_back(8'h5A);
      write_bytes(bq);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_tx", 64'(tx_o), 64'(1));
      bus_rd(UART_STATUS, rd); check("midrst_status", 64'(rd), 64'(st(0, 0, 1, 0, 0)));
      bq.delete(); bq.push_back(8'h96); exp_q.push_back(8'h96);
      write_bytes(bq);
      wait_idle(100, "post_rst_idle", n);

      // Random bursts that never exceed the FIFO
      for (int b = 0; b < 6; b++) begin
         int len = int'($urandom_range(DEPTH, 1));
         for (int i = 0; i < len; i++) begin
            logic [7:0] d = 8'($urandom_range(255, 0));
            exp_q.push_back(d);
            bus_wr(UART_TXDATA, 32'(d));
            repeat ($urandom_range(2, 0)) @(negedge clk);
         end
         wait_idle(DEPTH * 10 * BAUD + 50, "rand_idle", n);
      end

      // Interrupt on drained FIFO
      bus_wr(UART_CTRL, 32'h3);
      #1;
      check("irq_idle", 64'(irq_o), 64'(1));
      bq.delete(); bq.push_back(8'h7E); exp_q.push_back(8'h7E);
      write_bytes(bq);
      #1;
      n = 0;
      while (irq_o === 1'b0 && n < 100) begin
         n++;
         @(negedge clk); #1;
      end
      check("irq_low_cycles", 64'(n), 64'(10 * BAUD + 1));

      repeat (5) @(negedge clk);
      check("exp_q_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
